// File: rtl/alu_reset_sequencer.sv
// Programmable multi-channel reset pulse generator.
// It issues a power-on pulse after RST. On START it runs R pulses with programmable assert and
// gap lengths, a per-channel mask and an optional staggered release.
module alu_reset_sequencer #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned REP_WIDTH  = 4,
    parameter int unsigned POR_CYCLES = 8,
    parameter int unsigned STAGGER    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] ASSERT_LEN,
    input  logic [CNT_WIDTH-1:0] GAP_LEN,
    input  logic [REP_WIDTH-1:0] REPEAT,
    input  logic [CHANNELS-1:0]  CH_MASK,
    output logic [CHANNELS-1:0]  RST_OUT,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned REL_LEN = (CHANNELS - 1) * STAGGER + 1;
    localparam logic [CNT_WIDTH-1:0] POR_LAST = CNT_WIDTH'(POR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REL_LAST = CNT_WIDTH'(REL_LEN - 1);

    typedef enum logic [2:0] {
        S_POR,
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP,
        S_FIN
    } state_t;

    state_t               state, state_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic [CNT_WIDTH-1:0] a_len, a_len_d;
    logic [CNT_WIDTH-1:0] g_len, g_len_d;
    logic [REP_WIDTH-1:0] rem, rem_d;
    logic [CHANNELS-1:0]  mask, mask_d;
    logic                 por_seq, por_seq_d;
    logic [CHANNELS-1:0]  rel_out;
    logic [CHANNELS-1:0]  rst_out_d;

    // State, latched configuration and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_POR;
            cnt     <= '0;
            a_len   <= '0;
            g_len   <= '0;
            rem     <= '0;
            mask    <= '0;
            por_seq <= 1'b1;
            RST_OUT <= '1;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            a_len   <= a_len_d;
            g_len   <= g_len_d;
            rem     <= rem_d;
            mask    <= mask_d;
            por_seq <= por_seq_d;
            RST_OUT <= rst_out_d;
            BUSY    <= (state_d != S_IDLE);
            DONE    <= (state_d == S_FIN);
        end
    end

    // Next state and counters. The outputs are derived from the next state so that every
    // output is registered without an extra cycle of latency.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_WIDTH'(1);
        a_len_d   = a_len;
        g_len_d   = g_len;
        rem_d     = rem;
        mask_d    = mask;
        por_seq_d = por_seq;

        case (state)
            S_POR: begin
                if (cnt == POR_LAST) begin
                    state_d   = S_RELEASE;
                    cnt_d     = '0;
                    mask_d    = '1;
                    rem_d     = REP_WIDTH'(1);
                    por_seq_d = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (START && !ABORT) begin
                    state_d   = S_ASSERT;
                    a_len_d   = (ASSERT_LEN == '0) ? CNT_WIDTH'(1) : ASSERT_LEN;
                    g_len_d   = (GAP_LEN == '0) ? CNT_WIDTH'(1) : GAP_LEN;
                    rem_d     = (REPEAT == '0) ? REP_WIDTH'(1) : REPEAT;
                    mask_d    = CH_MASK;
                    por_seq_d = 1'b0;
                end
            end
            S_ASSERT: begin
                if (cnt == a_len - CNT_WIDTH'(1)) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (cnt == REL_LAST) begin
                    cnt_d = '0;
                    rem_d = rem - REP_WIDTH'(1);
                    if (rem == REP_WIDTH'(1)) begin
                        state_d = por_seq ? S_IDLE : S_FIN;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt == g_len - CNT_WIDTH'(1)) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The power-on sequence, including its release phase, cannot be aborted
        if (ABORT && !por_seq &&
            (state == S_ASSERT || state == S_RELEASE || state == S_GAP)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        rel_out = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            rel_out[i] = mask_d[i] && (32'(cnt_d) < i * STAGGER);
        end

        case (state_d)
            S_POR:     rst_out_d = '1;
            S_ASSERT:  rst_out_d = mask_d;
            S_RELEASE: rst_out_d = rel_out;
            default:   rst_out_d = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_reset_sequencer.sv
// Self-checking bench for alu_reset_sequencer. dut0 uses STAGGER=0 and dut1 uses STAGGER=2.
// A table of pulse configurations runs on dut0. Hand-written sequences cover the power-on
// pulse, staggered release, abort, start/abort collision and reset during a gap.
module tb_alu_reset_sequencer;

    typedef struct {
        logic [15:0] a;
        logic [15:0] g;
        logic [3:0]  r;
        logic [3:0]  mask;
        logic [3:0]  eff_mask;
        int unsigned a_eff;
        int unsigned g_eff;
        int unsigned r_eff;
        int unsigned done_idx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] a_len = '0;
    logic [15:0] g_len = '0;
    logic [3:0]  rep = '0;
    logic [3:0]  mask = '0;
    logic [3:0]  rst_out0, rst_out1;
    logic        busy0, busy1, done0, done1;

    int total = 0;
    int bad = 0;

    vec_t vecs[5];
    logic [3:0] por1[16];
    logic [3:0] stag[13];

    alu_reset_sequencer #(.CHANNELS(4), .CNT_WIDTH(16), .REP_WIDTH(4), .POR_CYCLES(8), .STAGGER(0)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .ASSERT_LEN(a_len), .GAP_LEN(g_len), .REPEAT(rep), .CH_MASK(mask),
        .RST_OUT(rst_out0), .BUSY(busy0), .DONE(done0)
    );

    alu_reset_sequencer #(.CHANNELS(4), .CNT_WIDTH(16), .REP_WIDTH(4), .POR_CYCLES(8), .STAGGER(2)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .ABORT(abort),
        .ASSERT_LEN(a_len), .GAP_LEN(g_len), .REPEAT(rep), .CH_MASK(mask),
        .RST_OUT(rst_out1), .BUSY(busy1), .DONE(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered right after an edge that sampled rst=1; releases rst and follows both power-on pulses
    task automatic por_check(input bit with_abort);
        check("por_rst_hold", rst_out0, 4'hF);
        check("por_busy_hold", busy0, 1);
        check("por_done_hold", done0, 0);
        rst = 1'b0;
        abort = with_abort;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("por_rst0", rst_out0, (k <= 7) ? 4'hF : 4'h0);
            check("por_busy0", busy0, (k <= 8) ? 1 : 0);
            check("por_done0", done0, 0);
            check("por_rst1", rst_out1, por1[k]);
            check("por_busy1", busy1, (k <= 14) ? 1 : 0);
            check("por_done1", done1, 0);
        end
        abort = 1'b0;
    endtask

    // Runs one table entry on dut0; inputs are scrambled after START and a stray START is sent
    task automatic run_vec(input int idx);
        vec_t v;
        int unsigned per, p, off;
        logic [3:0] exp_rst;
        v = vecs[idx];
        a_len = v.a;
        g_len = v.g;
        rep = v.r;
        mask = v.mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_len = 16'd7;
        g_len = 16'd9;
        rep = 4'd5;
        mask = ~v.mask;
        per = v.a_eff + 1 + v.g_eff;
        for (int unsigned k = 0; k <= v.done_idx + 1; k++) begin
            p = k / per;
            off = k % per;
            exp_rst = (k <= v.done_idx && p < v.r_eff && off < v.a_eff) ? v.eff_mask : 4'h0;
            check($sformatf("vec%0d_rst", idx), rst_out0, exp_rst);
            check($sformatf("vec%0d_busy", idx), busy0, (k <= v.done_idx) ? 1 : 0);
            check($sformatf("vec%0d_done", idx), done0, (k == v.done_idx) ? 1 : 0);
            start = (k == 0);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'd5, 16'd3, 4'd2, 4'b1011, 4'b1011, 5, 3, 2, 15};
        vecs[1] = '{16'd0, 16'd0, 4'd0, 4'b1111, 4'b1111, 1, 1, 1, 2};
        vecs[2] = '{16'd1, 16'd1, 4'd3, 4'b0001, 4'b0001, 1, 1, 3, 8};
        vecs[3] = '{16'd3, 16'd0, 4'd2, 4'b0110, 4'b0110, 3, 1, 2, 9};
        vecs[4] = '{16'd2, 16'd4, 4'd1, 4'b0000, 4'b0000, 2, 4, 1, 3};
        por1 = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};
        stag = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};

        // Reset held three cycles, then the power-on pulse
        rst = 1'b1;
        tick();
        tick();
        tick();
        por_check(1'b0);

        // Table-driven sequences on dut0
        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        // Staggered release on dut1: A=4, R=1, all channels
        a_len = 16'd4;
        g_len = 16'd0;
        rep = 4'd1;
        mask = 4'hF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            check("stag_rst", rst_out1, stag[k]);
            check("stag_busy", busy1, (k <= 11) ? 1 : 0);
            check("stag_done", done1, (k == 11) ? 1 : 0);
            tick();
        end

        // Abort on the third assert cycle of the first pulse
        a_len = 16'd10;
        g_len = 16'd2;
        rep = 4'd3;
        mask = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_rst", rst_out0, 4'hF);
        check("abort_pre_busy", busy0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("abort_rst", rst_out0, 4'h0);
            check("abort_busy", busy0, 0);
            check("abort_done", done0, 0);
            tick();
        end
        run_vec(0);

        // START together with ABORT in IDLE starts nothing
        a_len = 16'd3;
        rep = 4'd1;
        mask = 4'hF;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("startabort_rst", rst_out0, 4'h0);
            check("startabort_busy", busy0, 0);
            tick();
        end

        // Reset during a gap, then a power-on pulse that ignores ABORT
        a_len = 16'd2;
        g_len = 16'd5;
        rep = 4'd2;
        mask = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        check("gap_rst", rst_out0, 4'h0);
        check("gap_busy", busy0, 1);
        rst = 1'b1;
        tick();
        por_check(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
